next_pc_unit: RTL



---
 rtl/pc_pkg.sv | 13 +
 rtl/next_pc_sel.sv | 53 +++++
 rtl/next_pc_unit.sv | 67 ++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the next-PC datapath.
package pc_pkg;

  typedef enum logic [1:0] {PC_SEQ, PC_TARGET, PC_TRAP} next_pc_e;

  localparam int IALIGN_BYTES = 4;
  localparam int MAX_XLEN     = 128;

  function automatic logic [MAX_XLEN-1:0] align4(input logic [MAX_XLEN-1:0] addr);
    return addr & ~MAX_XLEN'(3);
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC priority select: stall > trap > misaligned target > target > sequential.
module next_pc_sel
  import pc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            stall,
  input  logic            trap_req,
  input  logic            next_pc_src,
  input  logic [XLEN-1:0] alu_res,
  input  logic [XLEN-1:0] trap_vec,
  input  logic [XLEN-1:0] pc,
  output next_pc_e        sel,
  output logic [XLEN-1:0] next_pc,
  output logic            misalign,
  output logic            retire
);

  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] trap_base;
  logic            tgt_bad;

  // JALR clears bit 0; bit 1 set means the target is not 4-byte aligned.
  assign tgt       = alu_res & ~XLEN'(1);
  assign tgt_bad   = tgt[1];
  assign trap_base = XLEN'(align4(MAX_XLEN'(trap_vec)));

  always_comb begin
    sel      = PC_SEQ;
    next_pc  = pc + XLEN'(IALIGN_BYTES);
    misalign = 1'b0;
    retire   = 1'b0;
    if (stall) begin
      next_pc = pc;
    end else if (trap_req) begin
      sel     = PC_TRAP;
      next_pc = trap_base;
    end else if (next_pc_src) begin
      if (tgt_bad) begin
        sel      = PC_TRAP;
        next_pc  = trap_base;
        misalign = 1'b1;
      end else begin
        sel     = PC_TARGET;
        next_pc = tgt;
        retire  = 1'b1;
      end
    end else begin
      retire = 1'b1;
    end
  end

endmodule

// File: rtl/next_pc_unit.sv
// Architectural PC register with trap redirect, faulting-PC capture, stall and retire counter.
module next_pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter int              INSTRET_W    = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 NextPCSrc,
  input  logic [XLEN-1:0]      ALURes,
  input  logic                 trap_req,
  input  logic [XLEN-1:0]      trap_vec,
  output logic [XLEN-1:0]      PC,
  output logic [XLEN-1:0]      PCPlus4,
  output logic [XLEN-1:0]      epc,
  output logic                 misaligned,
  output logic [INSTRET_W-1:0] instret
);

  if (RESET_VECTOR[1:0] != 2'b00) begin : g_bad_reset_vector
    $error("next_pc_unit: RESET_VECTOR must be 4-byte aligned");
  end
  if (XLEN < 32 || XLEN > MAX_XLEN) begin : g_bad_xlen
    $error("next_pc_unit: XLEN out of supported range");
  end

  next_pc_e        sel;
  logic [XLEN-1:0] next_pc;
  logic            misalign;
  logic            retire;

  assign PCPlus4 = PC + XLEN'(IALIGN_BYTES);

  next_pc_sel #(.XLEN(XLEN)) u_sel (
    .stall       (stall),
    .trap_req    (trap_req),
    .next_pc_src (NextPCSrc),
    .alu_res     (ALURes),
    .trap_vec    (trap_vec),
    .pc          (PC),
    .sel         (sel),
    .next_pc     (next_pc),
    .misalign    (misalign),
    .retire      (retire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC         <= RESET_VECTOR;
      epc        <= '0;
      misaligned <= 1'b0;
      instret    <= '0;
    end else begin
      // misalign is already forced low by the selector while stalled
      misaligned <= misalign;
      if (!stall) begin
        PC <= next_pc;
        if (sel == PC_TRAP) epc <= PC;
        if (retire) instret <= instret + INSTRET_W'(1);
      end
    end
  end

endmodule
